// File: rtl/mips_encode_pkg.sv
// Shared MIPS opcode/funct constants, encoder mnemonic indices and format helpers.
package mips_encode_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] OP0_JR     = 6'h08;
  localparam logic [5:0] OP0_ADD    = 6'h20;
  localparam logic [5:0] OP0_SUB    = 6'h22;
  localparam logic [5:0] OP0_AND    = 6'h24;
  localparam logic [5:0] OP0_OR     = 6'h25;
  localparam logic [5:0] OP0_XOR    = 6'h26;
  localparam logic [5:0] OP0_NOR    = 6'h27;
  localparam logic [5:0] OP0_SLT    = 6'h2a;
  localparam logic [5:0] OP0_ADDM   = 6'h2c;

  localparam logic [4:0] MNEM_ADD  = 5'd0;
  localparam logic [4:0] MNEM_SUB  = 5'd1;
  localparam logic [4:0] MNEM_AND  = 5'd2;
  localparam logic [4:0] MNEM_OR   = 5'd3;
  localparam logic [4:0] MNEM_NOR  = 5'd4;
  localparam logic [4:0] MNEM_XOR  = 5'd5;
  localparam logic [4:0] MNEM_SLT  = 5'd6;
  localparam logic [4:0] MNEM_JR   = 5'd7;
  localparam logic [4:0] MNEM_ADDM = 5'd8;
  localparam logic [4:0] MNEM_ADDI = 5'd9;
  localparam logic [4:0] MNEM_ANDI = 5'd10;
  localparam logic [4:0] MNEM_ORI  = 5'd11;
  localparam logic [4:0] MNEM_XORI = 5'd12;
  localparam logic [4:0] MNEM_LUI  = 5'd13;
  localparam logic [4:0] MNEM_BEQ  = 5'd14;
  localparam logic [4:0] MNEM_BNE  = 5'd15;
  localparam logic [4:0] MNEM_LW   = 5'd16;
  localparam logic [4:0] MNEM_LBU  = 5'd17;
  localparam logic [4:0] MNEM_SW   = 5'd18;
  localparam logic [4:0] MNEM_SB   = 5'd19;
  localparam logic [4:0] MNEM_J    = 5'd20;
  localparam logic [4:0] MNEM_LAST = 5'd20;

  typedef enum logic [2:0] {FmtR, FmtJr, FmtI, FmtLui, FmtJ, FmtIllegal} fmt_e;

  function automatic fmt_e mnem_fmt(input logic [4:0] m);
    fmt_e f;
    if (m == MNEM_JR)        f = FmtJr;
    else if (m <= MNEM_ADDM) f = FmtR;
    else if (m == MNEM_LUI)  f = FmtLui;
    else if (m <= MNEM_SB)   f = FmtI;
    else if (m == MNEM_J)    f = FmtJ;
    else                     f = FmtIllegal;
    return f;
  endfunction

  // Funct for R-type mnemonics, primary opcode for everything else.
  function automatic logic [5:0] mnem_code(input logic [4:0] m);
    logic [5:0] c;
    case (m)
      MNEM_ADD:  c = OP0_ADD;
      MNEM_SUB:  c = OP0_SUB;
      MNEM_AND:  c = OP0_AND;
      MNEM_OR:   c = OP0_OR;
      MNEM_NOR:  c = OP0_NOR;
      MNEM_XOR:  c = OP0_XOR;
      MNEM_SLT:  c = OP0_SLT;
      MNEM_JR:   c = OP0_JR;
      MNEM_ADDM: c = OP0_ADDM;
      MNEM_ADDI: c = OP_ADDI;
      MNEM_ANDI: c = OP_ANDI;
      MNEM_ORI:  c = OP_ORI;
      MNEM_XORI: c = OP_XORI;
      MNEM_LUI:  c = OP_LUI;
      MNEM_BEQ:  c = OP_BEQ;
      MNEM_BNE:  c = OP_BNE;
      MNEM_LW:   c = OP_LW;
      MNEM_LBU:  c = OP_LBU;
      MNEM_SW:   c = OP_SW;
      MNEM_SB:   c = OP_SB;
      MNEM_J:    c = OP_J;
      default:   c = 6'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_encode_fifo.sv
// DEPTH x 32 synchronous FIFO; push is ignored when full, pop is ignored when empty.
module mips_encode_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Zero on empty so the output reads 0 straight after reset.
  assign rd_data = empty ? 32'h0 : mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/mips_encode.sv
// MIPS instruction encoder feeding a word FIFO with an incrementing output address.
// Define MIPS_ENC_FIELD_CHECK_EN to also reject requests with nonzero unused fields.
module mips_encode
  import mips_encode_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              except,
  output logic [7:0]        err_cnt
);

  fmt_e              fmt;
  logic [5:0]        code;
  logic              legal;
  logic [31:0]       word;
  logic              accept, push, bad, pop, full, empty;
  logic              except_q;
  logic [7:0]        err_cnt_q;
  logic [ADDR_W-1:0] addr_q;

  always_comb begin
    fmt   = mnem_fmt(mnem);
    code  = mnem_code(mnem);
    legal = (fmt != FmtIllegal);
    case (fmt)
      FmtR:    word = {OP_SPECIAL, rs, rt, rd, 5'b0, code};
      FmtJr:   word = {OP_SPECIAL, rs, 15'b0, code};
      FmtI:    word = {code, rs, rt, imm};
      FmtLui:  word = {code, 5'b0, rt, imm};
      FmtJ:    word = {code, target};
      default: word = 32'h0;
    endcase
`ifdef MIPS_ENC_FIELD_CHECK_EN
    case (fmt)
      FmtR:    if (imm != '0 || target != '0) legal = 1'b0;
      FmtJr:   if (rt != '0 || rd != '0 || imm != '0 || target != '0) legal = 1'b0;
      FmtI:    if (rd != '0 || target != '0) legal = 1'b0;
      FmtLui:  if (rs != '0 || rd != '0 || target != '0) legal = 1'b0;
      FmtJ:    if (rs != '0 || rt != '0 || rd != '0 || imm != '0) legal = 1'b0;
      default: legal = 1'b0;
    endcase
`endif
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign push      = accept & legal;
  assign bad       = accept & ~legal;
  assign pop       = out_valid & out_ready;

  mips_encode_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .rd_data   (out_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      except_q  <= 1'b0;
      err_cnt_q <= 8'h00;
      addr_q    <= ADDR_W'(BASE_ADDR);
    end else begin
      except_q <= bad;
      if (bad && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 1'b1;
      if (pop) addr_q <= addr_q + 1'b1;
    end
  end

  assign except   = except_q;
  assign err_cnt  = err_cnt_q;
  assign out_addr = addr_q;

endmodule

// File: tb/tb_mips_encode.sv
// Directed table-driven bench for mips_encode, plus sequences for FIFO, error and reset corners.
module tb_mips_encode;
  import mips_encode_pkg::*;

  logic        clock, reset;
  logic        in_valid, in_ready, out_valid, out_ready, except;
  logic [4:0]  mnem, rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] out_data;
  logic [29:0] out_addr;
  logic [7:0]  err_cnt;

  logic        in_ready2, out_valid2, except2;
  logic [31:0] out_data2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_cnt2;

  int checks = 0;
  int failures = 0;

  mips_encode #(.DEPTH(4), .ADDR_W(30), .BASE_ADDR(0)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mnem(mnem),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .except(except),
    .err_cnt(err_cnt)
  );

  // Narrow-address copy with a nonzero base, fed the same stimulus.
  mips_encode #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(3)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .mnem(mnem),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_addr(out_addr2), .except(except2),
    .err_cnt(err_cnt2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  localparam int NVec = 21;
  vec_t vecs [NVec];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_req(input logic [4:0] m, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
    mnem = m; rs = s; rt = t; rd = d; imm = i; target = g;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int got;
    logic accept5;
    logic [1:0] e2;

    vecs[0]  = '{MNEM_ADD,  5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h00221820};
    vecs[1]  = '{MNEM_ADDI, 5'd0,  5'd8, 5'd0, 16'h5,    26'h0,       32'h20080005};
    vecs[2]  = '{MNEM_LUI,  5'd0,  5'd1, 5'd0, 16'h1234, 26'h0,       32'h3C011234};
    vecs[3]  = '{MNEM_LW,   5'd29, 5'd4, 5'd0, 16'h8,    26'h0,       32'h8FA40008};
    vecs[4]  = '{MNEM_J,    5'd0,  5'd0, 5'd0, 16'h0,    26'h40,      32'h08000040};
    vecs[5]  = '{MNEM_SUB,  5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h00221822};
    vecs[6]  = '{MNEM_AND,  5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h00221824};
    vecs[7]  = '{MNEM_OR,   5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h00221825};
    vecs[8]  = '{MNEM_NOR,  5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h00221827};
    vecs[9]  = '{MNEM_XOR,  5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h00221826};
    vecs[10] = '{MNEM_SLT,  5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h0022182A};
    vecs[11] = '{MNEM_JR,   5'd31, 5'd0, 5'd0, 16'h0,    26'h0,       32'h03E00008};
    vecs[12] = '{MNEM_ADDM, 5'd1,  5'd2, 5'd3, 16'h0,    26'h0,       32'h0022182C};
    vecs[13] = '{MNEM_ANDI, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0,       32'h3022FFFF};
    vecs[14] = '{MNEM_ORI,  5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0,       32'h3422FFFF};
    vecs[15] = '{MNEM_XORI, 5'd1,  5'd2, 5'd0, 16'hFFFF, 26'h0,       32'h3822FFFF};
    vecs[16] = '{MNEM_BEQ,  5'd1,  5'd2, 5'd0, 16'hFFFE, 26'h0,       32'h1022FFFE};
    vecs[17] = '{MNEM_BNE,  5'd1,  5'd2, 5'd0, 16'hFFFE, 26'h0,       32'h1422FFFE};
    vecs[18] = '{MNEM_LBU,  5'd29, 5'd4, 5'd0, 16'h8,    26'h0,       32'h93A40008};
    vecs[19] = '{MNEM_SW,   5'd29, 5'd4, 5'd0, 16'h8,    26'h0,       32'hAFA40008};
    vecs[20] = '{MNEM_SB,   5'd29, 5'd4, 5'd0, 16'h8,    26'h0,       32'hA3A40008};

    set_req(5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    do_reset();
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_addr", {2'b0, out_addr}, 32'd0);
    check("rst out_addr2", {30'b0, out_addr2}, 32'd3);
    check("rst except", {31'b0, except}, 32'd0);
    check("rst err_cnt", {24'b0, err_cnt}, 32'd0);
    check("rst out_data", out_data, 32'd0);

    // Streaming encode: one request per cycle, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NVec; i++) begin
      set_req(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].target);
      in_valid = 1'b1;
      step();
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d out_addr", i), {2'b0, out_addr}, i);
      check($sformatf("vec%0d except", i), {31'b0, except}, 32'd0);
    end
    in_valid = 1'b0;
    step();
    check("drain out_valid", {31'b0, out_valid}, 32'd0);

    // Fill to full with consumer stalled, then drain with the fifth request waiting.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      set_req(MNEM_ADDI, 5'd0, 5'd8, 5'd0, 16'(k), 26'h0);
      in_valid = 1'b1;
      check($sformatf("fill%0d in_ready", k), {31'b0, in_ready}, 32'd1);
      step();
    end
    set_req(MNEM_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'h0);
    for (int c = 0; c < 2; c++) begin
      check("full in_ready", {31'b0, in_ready}, 32'd0);
      check("full stall data", out_data, 32'h20080001);
      check("full stall addr", {2'b0, out_addr}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (out_valid) begin
        check($sformatf("drain%0d data", got), out_data, 32'h20080000 | (got + 1));
        check($sformatf("drain%0d addr", got), {2'b0, out_addr}, got);
        got++;
      end
      accept5 = in_valid & in_ready;
      step();
      if (accept5) in_valid = 1'b0;
    end
    check("drain count", got, 32'd5);
    check("drain empty", {31'b0, out_valid}, 32'd0);

    // Illegal mnemonics.
    do_reset();
    set_req(5'd25, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("ill25 except", {31'b0, except}, 32'd1);
    check("ill25 err_cnt", {24'b0, err_cnt}, 32'd1);
    check("ill25 out_valid", {31'b0, out_valid}, 32'd0);
    step();
    check("ill25 except drop", {31'b0, except}, 32'd0);
    set_req(5'd21, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    step();
    check("ill21 except", {31'b0, except}, 32'd1);
    check("ill21 err_cnt", {24'b0, err_cnt}, 32'd2);
    set_req(5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    step();
    in_valid = 1'b0;
    check("ill31 b2b except", {31'b0, except}, 32'd1);
    check("ill31 err_cnt", {24'b0, err_cnt}, 32'd3);
    step();
    check("ill b2b except drop", {31'b0, except}, 32'd0);
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) step();
    in_valid = 1'b0;
    step();
    check("err_cnt saturate", {24'b0, err_cnt}, 32'd255);
    check("illegal no enqueue", {31'b0, out_valid}, 32'd0);

    // Narrow address wraps modulo 4 from base 3.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(MNEM_ADDI, 5'd0, 5'd8, 5'd0, 16'(i + 1), 26'h0);
      in_valid = 1'b1;
      step();
      e2 = 2'(3 + i);
      check($sformatf("wrap%0d out_valid2", i), {31'b0, out_valid2}, 32'd1);
      check($sformatf("wrap%0d data2", i), out_data2, 32'h20080000 | (i + 1));
      check($sformatf("wrap%0d addr2", i), {30'b0, out_addr2}, {30'b0, e2});
      check($sformatf("wrap%0d addr", i), {2'b0, out_addr}, i);
    end
    in_valid = 1'b0;
    step();

    // Mid-stream reset with queued words, a nonzero address and error count.
    do_reset();
    set_req(MNEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    set_req(5'd30, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    in_valid = 1'b1;
    step();
    check("pre-rst addr", {2'b0, out_addr}, 32'd1);
    check("pre-rst err_cnt", {24'b0, err_cnt}, 32'd1);
    check("pre-rst out_valid", {31'b0, out_valid}, 32'd1);
    set_req(MNEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    check("mid-rst out_valid", {31'b0, out_valid}, 32'd0);
    check("mid-rst in_ready", {31'b0, in_ready}, 32'd1);
    check("mid-rst out_addr", {2'b0, out_addr}, 32'd0);
    check("mid-rst out_addr2", {30'b0, out_addr2}, 32'd3);
    check("mid-rst err_cnt", {24'b0, err_cnt}, 32'd0);
    check("mid-rst except", {31'b0, except}, 32'd0);
    check("mid-rst out_data", out_data, 32'd0);

    // Unused-field handling: add with imm=1.
    out_ready = 1'b0;
    set_req(MNEM_ADD, 5'd1, 5'd2, 5'd3, 16'h1, 26'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef MIPS_ENC_FIELD_CHECK_EN
    check("fchk except", {31'b0, except}, 32'd1);
    check("fchk err_cnt", {24'b0, err_cnt}, 32'd1);
    check("fchk out_valid", {31'b0, out_valid}, 32'd0);
`else
    check("nofchk except", {31'b0, except}, 32'd0);
    check("nofchk out_valid", {31'b0, out_valid}, 32'd1);
    check("nofchk out_data", out_data, 32'h00221820);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
